trap_ctrl: RTL

- Trap/return sequencer that sits directly upstream of the machine-mode CSR file.
- Collects exception flags from the retiring instruction in the MEM stage, plus the timer and external interrupt lines.
- Chooses one trap cause and drives the CSR file's trap-entry inputs (trap, mret, mepc_in, mcause_in, mtval_in).
- Issues a pipeline flush and a PC redirect to mtvec (trap) or mepc (mret).

---
 rtl/trap_pkg.sv | 44 ++++
 rtl/trap_prio.sv | 96 +++++++++
 rtl/trap_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the machine-mode trap/return sequencer:
//   - mcause encodings for every trap cause the sequencer can take
//   - mstatus / mie bit positions used for interrupt gating
//   - sequencer state encoding
//   - the event descriptor captured on the detecting edge
// -----------------------------------------------------------------------------
package trap_pkg;

    localparam int DATA_W = 32;

    // mcause values; bit 31 set marks an interrupt.
    localparam logic [DATA_W-1:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [DATA_W-1:0] CAUSE_BREAK   = 32'd3;
    localparam logic [DATA_W-1:0] CAUSE_LD_MIS  = 32'd4;
    localparam logic [DATA_W-1:0] CAUSE_ST_MIS  = 32'd6;
    localparam logic [DATA_W-1:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [DATA_W-1:0] CAUSE_MTI     = 32'h8000_0007;
    localparam logic [DATA_W-1:0] CAUSE_MEI     = 32'h8000_000B;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    // mie bit positions
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FIRE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Captured event: kind (trap or mret) plus the CSR values a trap writes.
    typedef struct packed {
        logic              is_mret;
        logic [DATA_W-1:0] cause;
        logic [DATA_W-1:0] epc;
        logic [DATA_W-1:0] tval;
    } trap_desc_t;

endpackage

// File: rtl/trap_prio.sv
// -----------------------------------------------------------------------------
// trap_prio
// Purely combinational priority encoder that picks one event from the MEM-stage
// exception flags, MRET and the enabled interrupt lines.
// Priority (highest first): ext int, timer int, illegal, ebreak, ecall,
// load misaligned, store misaligned, mret.
//
// Ports:
//   valid                  MEM instruction valid / retiring
//   pc, inst, addr         MEM-stage PC, instruction word, effective address
//   exc_*                  exception flags
//   is_mret                MEM instruction is MRET
//   irq_timer, irq_ext     level interrupt requests
//   mstatus, mie           current CSR values used for interrupt gating
//   take                   an event is present
//   take_mret              the chosen event is an MRET (no trap)
//   cause, tval            mcause / mtval for the chosen trap (0 for mret)
// -----------------------------------------------------------------------------
module trap_prio
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] addr,
    input  logic            exc_illegal,
    input  logic            exc_ecall,
    input  logic            exc_ebreak,
    input  logic            exc_ld_mis,
    input  logic            exc_st_mis,
    input  logic            is_mret,
    input  logic            irq_timer,
    input  logic            irq_ext,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    output logic            take,
    output logic            take_mret,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] tval
);

    logic irq_glb_en;
    logic ext_hit;
    logic tim_hit;

    assign irq_glb_en = mstatus[MSTATUS_MIE];
    assign ext_hit    = irq_glb_en && irq_ext   && mie[MIE_MEIE];
    assign tim_hit    = irq_glb_en && irq_timer && mie[MIE_MTIE];

    // Only single bits of mstatus/mie matter here.
    logic unused_csr_bits;
    assign unused_csr_bits = ^{mstatus, mie};

    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path
        // leaves a signal unassigned, which would infer a latch.
        take      = 1'b0;
        take_mret = 1'b0;
        cause     = '0;
        tval      = '0;
        if (valid) begin
            if (ext_hit) begin
                take  = 1'b1;
                cause = CAUSE_MEI;
            end else if (tim_hit) begin
                take  = 1'b1;
                cause = CAUSE_MTI;
            end else if (exc_illegal) begin
                take  = 1'b1;
                cause = CAUSE_ILLEGAL;
                tval  = inst;
            end else if (exc_ebreak) begin
                take  = 1'b1;
                cause = CAUSE_BREAK;
                tval  = pc;
            end else if (exc_ecall) begin
                take  = 1'b1;
                cause = CAUSE_ECALL_M;
            end else if (exc_ld_mis) begin
                take  = 1'b1;
                cause = CAUSE_LD_MIS;
                tval  = addr;
            end else if (exc_st_mis) begin
                take  = 1'b1;
                cause = CAUSE_ST_MIS;
                tval  = addr;
            end else if (is_mret) begin
                take      = 1'b1;
                take_mret = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Trap/return sequencer upstream of the machine-mode CSR file. Picks one event
// from the retiring MEM-stage instruction and the interrupt lines, waits out
// any in-flight CSR write, then issues a one-cycle trap or mret strobe together
// with flush and PC redirect, followed by FLUSH_HOLD cycles of drain.
//
// Parameters:
//   XLEN        datapath width (32)
//   FLUSH_HOLD  drain cycles after the redirect (1..3)
//
// Optional build macro:
//   TRAP_VECTORED_MTVEC_EN  when defined, interrupts with mtvec[1:0]=01 vector
//                           to base + 4*cause[3:0]; otherwise direct mode only.
//
// Ports:
//   clk, rst                     clock; synchronous active-low reset
//   mem_valid/pc/inst/addr       retiring MEM-stage instruction
//   exc_*, is_mret               exception flags and MRET marker
//   irq_timer, irq_ext           level interrupt requests
//   csr_w                        CSR-instruction write in progress
//   mstatus, mie, mtvec, mepc,
//   mcause_cur, mtval_cur        current CSR values
//   trap, mret                   one-cycle strobes to the CSR file
//   mepc_in, mcause_in, mtval_in values the CSR file latches on the strobe
//   redirect, redirect_pc        PC redirect strobe and target
//   flush                        kill IF/ID/EX/MEM
//   stall                        freeze pipeline while an event is held
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FLUSH_HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [XLEN-1:0] mem_inst,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            exc_illegal,
    input  logic            exc_ecall,
    input  logic            exc_ebreak,
    input  logic            exc_ld_mis,
    input  logic            exc_st_mis,
    input  logic            is_mret,
    input  logic            irq_timer,
    input  logic            irq_ext,
    input  logic            csr_w,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mcause_cur,
    input  logic [XLEN-1:0] mtval_cur,
    output logic            trap,
    output logic            mret,
    output logic [XLEN-1:0] mepc_in,
    output logic [XLEN-1:0] mcause_in,
    output logic [XLEN-1:0] mtval_in,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            stall
);

    state_t          state;
    state_t          state_nxt;
    trap_desc_t      desc;
    logic [1:0]      drain_cnt;

    logic            p_take;
    logic            p_mret;
    logic [XLEN-1:0] p_cause;
    logic [XLEN-1:0] p_tval;
    logic            capture;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    trap_prio #(.XLEN(XLEN)) u_prio (
        .valid       (mem_valid),
        .pc          (mem_pc),
        .inst        (mem_inst),
        .addr        (mem_addr),
        .exc_illegal (exc_illegal),
        .exc_ecall   (exc_ecall),
        .exc_ebreak  (exc_ebreak),
        .exc_ld_mis  (exc_ld_mis),
        .exc_st_mis  (exc_st_mis),
        .is_mret     (is_mret),
        .irq_timer   (irq_timer),
        .irq_ext     (irq_ext),
        .mstatus     (mstatus),
        .mie         (mie),
        .take        (p_take),
        .take_mret   (p_mret),
        .cause       (p_cause),
        .tval        (p_tval)
    );

    // Events are only accepted in IDLE; HOLD/FIRE/DRAIN keep the descriptor.
    assign capture   = (state == ST_IDLE) && p_take;
    assign trap_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_MTVEC_EN
    // Only interrupts vector; synchronous exceptions always use the base.
    assign trap_target = (mtvec[1:0] == 2'b01 && desc.cause[XLEN-1])
                       ? trap_base + XLEN'({desc.cause[3:0], 2'b00})
                       : trap_base;
`else
    assign trap_target = trap_base;
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec[1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: state and descriptor use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state     <= ST_IDLE;
            // NOTE: the descriptor is reset even though FIRE is unreachable
            // without a fresh capture; it keeps post-reset state deterministic.
            desc      <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                desc.is_mret <= p_mret;
                desc.cause   <= p_cause;
                desc.epc     <= mem_pc;
                desc.tval    <= p_tval;
            end
            // Counter is armed in FIRE so DRAIN lasts exactly FLUSH_HOLD cycles.
            if (state == ST_FIRE) begin
                drain_cnt <= 2'(FLUSH_HOLD - 1);
            end else if (state == ST_DRAIN && drain_cnt != 2'd0) begin
                drain_cnt <= drain_cnt - 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        trap        = 1'b0;
        mret        = 1'b0;
        redirect    = 1'b0;
        flush       = 1'b0;
        stall       = 1'b0;
        redirect_pc = '0;
        mepc_in     = '0;
        mcause_in   = '0;
        mtval_in    = '0;
        case (state)
            ST_IDLE: begin
                // A CSR write in the same cycle would overwrite the strobe's
                // effect, so park in HOLD until it is gone.
                if (p_take) begin
                    state_nxt = csr_w ? ST_HOLD : ST_FIRE;
                end
            end
            ST_HOLD: begin
                stall = 1'b1;
                if (!csr_w) begin
                    state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
                flush     = 1'b1;
                redirect  = 1'b1;
                state_nxt = ST_DRAIN;
                if (desc.is_mret) begin
                    // Feed current values back so MRET leaves the CSRs intact.
                    mret        = 1'b1;
                    redirect_pc = mepc;
                    mepc_in     = mepc;
                    mcause_in   = mcause_cur;
                    mtval_in    = mtval_cur;
                end else begin
                    trap        = 1'b1;
                    redirect_pc = trap_target;
                    mepc_in     = desc.epc;
                    mcause_in   = desc.cause;
                    mtval_in    = desc.tval;
                end
            end
            ST_DRAIN: begin
                flush = 1'b1;
                if (drain_cnt == 2'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
